irq_collector: RTL
==================

IRQ_COLLECTOR -- requirements
Module: irq_collector

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16: number of interrupt lines, matches the control register file interrupt input width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on raw lines, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port irq_in, input, NUM_IRQ: raw asynchronous device interrupt lines.
REQ-006 SHALL have port stall, input, 1: pipeline stall; the control register file ignores interrupts while high.
REQ-007 SHALL have port interrupts, output, NUM_IRQ: pending lines driven to the control register file interrupt input.
REQ-008 SHALL have port cfg_wen, input, 1: kernel config write strobe.
REQ-009 SHALL have port cfg_addr, input, 2: config register select.
REQ-010 SHALL have port cfg_wdata, input, 32: config write data.
REQ-011 SHALL have port cfg_rdata, output, 32: config read data, combinational from cfg_addr.

Function
REQ-012 SHALL pass each irq_in bit through SYNC_STAGES flops; only the synchronized value (sync) is used downstream.
REQ-013 SHALL keep a sync_prev register holding last cycle's sync.
REQ-014 SHALL define event[i] = sync[i] & ~sync_prev[i] when edge_mode[i]=1, and event[i] = sync[i] when edge_mode[i]=0.
REQ-015 SHALL OR the timer tick into event[0].
REQ-016 SHALL drive interrupts directly from the pending register, no combinational path from irq_in or stall.
REQ-017 SHALL compute next pending = event when stall=0 (pending bits delivered this cycle), and pending | event when stall=1 (held, nothing lost).
REQ-018 SHALL, when an event and a delivery hit the same bit in the same cycle, leave that bit set the following cycle.
REQ-019 SHALL decode cfg registers: addr 0 edge_mode[NUM_IRQ-1:0]; addr 1 timer_reload[31:0]; addr 2 timer_ctrl, bit0 enable; addr 3 timer_count, read-only, writes ignored.
REQ-020 SHALL zero-extend unused upper bits on cfg_rdata reads.
REQ-021 SHALL, when enable=1 and count=0, assert tick for one cycle and load count <= timer_reload.
REQ-022 SHALL, when enable=1 and count!=0, decrement count by 1.
REQ-023 SHALL hold count when enable=0 and assert no tick.
REQ-024 SHALL, on a write to timer_ctrl setting enable while enable is 0, load count <= timer_reload that cycle with no tick.
REQ-025 SHALL, with timer_reload=0 and enable=1, tick every cycle.
REQ-026 SHALL apply a write to timer_reload while running only at the next reload, without disturbing the current count.
REQ-027 SHALL, on a write to timer_ctrl clearing enable, cancel any tick that cycle.
REQ-028 SHALL, on a change of edge_mode, apply the new mode to the next cycle's event only; already-pending bits are unaffected.
REQ-029 SHALL keep the timer 32-bit unsigned with no underflow past 0.

Reset
REQ-030 SHALL, while rst=1, clear sync flops, sync_prev, pending, timer_reload, count, and enable to 0, and set edge_mode to all ones.
REQ-031 SHALL drive interrupts=0 in the cycle after rst is asserted.
REQ-032 SHALL give rst priority over cfg_wen and events in the same cycle.
REQ-033 SHALL generate no spurious edge event on the first cycle after reset release while irq_in is already high; sync_prev tracks sync from reset.

Verification
REQ-034 SHALL be verified: irq_in[5] rises, stall=0 -> interrupts[5]=1 for exactly one cycle, 3 cycles after the rise (2 sync stages + pending).
REQ-035 SHALL be verified: irq_in[5] pulse while stall=1 for 10 cycles -> interrupts[5] stays 1 until the first cycle with stall=0, then clears.
REQ-036 SHALL be verified: edge_mode=0xFFFE, irq_in[0] held high -> interrupts[0]=1 every cycle; irq_in[1] held high -> one-cycle pulse only.
REQ-037 SHALL be verified: reload=4, enable written 1 -> tick at cycles 5, 10, 15 after the write; cfg_rdata@3 counts 4,3,2,1,0.
REQ-038 SHALL be verified: event on bit 2 in the same cycle as delivery of bit 2 (stall=0) -> interrupts[2]=1 on the next cycle.
REQ-039 SHALL be verified: rst asserted with pending=0x0011 and timer running -> interrupts=0, enable=0, edge_mode reads 0xFFFF.

Source files
------------

// File: rtl/irq_collector.sv
// Interrupt collector: synchronizes raw device lines, detects edges or levels, merges a periodic
// timer tick into line 0 and holds pending lines across pipeline stalls.
module irq_collector #(
  parameter int unsigned NUM_IRQ     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               stall,
  output logic [NUM_IRQ-1:0] interrupts,
  input  logic               cfg_wen,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata
);

  // Never build a synchronizer shallower than two flops.
  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  irq_vec_t    sync_q [Stages];
  irq_vec_t    sync;
  irq_vec_t    sync_prev_q;
  irq_vec_t    edge_mode_q, edge_mode_d;
  irq_vec_t    pending_q, pending_d;
  irq_vec_t    irq_event;
  logic [31:0] reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic        enable_q, enable_d;
  logic        wr_mode, wr_reload, wr_ctrl;
  logic        timer_start, timer_stop, tick;

  assign sync       = sync_q[Stages-1];
  assign interrupts = pending_q;

  assign wr_mode   = cfg_wen && (cfg_addr == 2'd0);
  assign wr_reload = cfg_wen && (cfg_addr == 2'd1);
  assign wr_ctrl   = cfg_wen && (cfg_addr == 2'd2);

  // Enabling from idle loads the counter without ticking; disabling suppresses this cycle's tick.
  assign timer_start = wr_ctrl && cfg_wdata[0] && !enable_q;
  assign timer_stop  = wr_ctrl && !cfg_wdata[0];
  assign tick        = enable_q && (count_q == 32'd0) && !timer_stop;

  always_comb begin
    irq_event    = (edge_mode_q & sync & ~sync_prev_q) | (~edge_mode_q & sync);
    irq_event[0] = irq_event[0] | tick;
    // A stalled pipeline cannot take interrupts, so accumulate instead of replacing.
    pending_d    = stall ? (pending_q | irq_event) : irq_event;
  end

  always_comb begin
    edge_mode_d = wr_mode   ? cfg_wdata[NUM_IRQ-1:0] : edge_mode_q;
    reload_d    = wr_reload ? cfg_wdata : reload_q;
    enable_d    = wr_ctrl   ? cfg_wdata[0] : enable_q;
    count_d     = count_q;
    if (timer_start) begin
      count_d = reload_q;
    end else if (enable_q && !timer_stop) begin
      count_d = (count_q == 32'd0) ? reload_q : count_q - 32'd1;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0:    cfg_rdata = 32'(edge_mode_q);
      2'd1:    cfg_rdata = reload_q;
      2'd2:    cfg_rdata = {31'd0, enable_q};
      2'd3:    cfg_rdata = count_q;
      default: cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Stages; i++) begin
        sync_q[i] <= '0;
      end
      sync_prev_q <= '0;
      edge_mode_q <= '1;
      pending_q   <= '0;
      reload_q    <= '0;
      count_q     <= '0;
      enable_q    <= 1'b0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_prev_q <= sync;
      edge_mode_q <= edge_mode_d;
      pending_q   <= pending_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
    end
  end

endmodule
